psg_multi: RTL

- Parametrised PSG successor for the sound subsystem. NCH square-tone channels, one shared noise LFSR and one envelope generator with full 16-shape semantics.
- Everything runs on a single system clock. The audio rate comes from an internal clock-enable prescaler, not from a separate sound clock.
- Host bus is a 2-address select/data port with register readback. Output is a summed, log-DAC-weighted PCM word for the audio DAC/PWM stage.

---
 rtl/psg_pkg.sv | 92 +++++++++
 rtl/psg_tone_ch.sv | 42 ++++
 rtl/psg_multi.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/psg_pkg.sv
// psg_pkg: shared definitions for the multi-channel PSG.
//   - envelope shape bit positions
//   - register-number helpers (functions of the channel count)
//   - reset value for the per-channel mask registers
//   - output word width
//   - 16-entry logarithmic DAC table
package psg_pkg;

  // Bit positions inside the 4-bit shape register.
  localparam int SH_HOLD = 0;
  localparam int SH_ALT  = 1;
  localparam int SH_ATT  = 2;
  localparam int SH_CONT = 3;

  function automatic int reg_tone_lo(input int c);
    return 2 * c;
  endfunction

  function automatic int reg_tone_hi(input int c);
    return 2 * c + 1;
  endfunction

  function automatic int reg_amp(input int nch, input int c);
    return 2 * nch + c;
  endfunction

  function automatic int reg_noise(input int nch);
    return 3 * nch;
  endfunction

  function automatic int reg_tdis(input int nch);
    return 3 * nch + 1;
  endfunction

  function automatic int reg_ndis(input int nch);
    return 3 * nch + 2;
  endfunction

  function automatic int reg_env_lo(input int nch);
    return 3 * nch + 3;
  endfunction

  function automatic int reg_env_hi(input int nch);
    return 3 * nch + 4;
  endfunction

  function automatic int reg_shape(input int nch);
    return 3 * nch + 5;
  endfunction

  function automatic int reg_pan_l(input int nch);
    return 3 * nch + 6;
  endfunction

  function automatic int reg_pan_r(input int nch);
    return 3 * nch + 7;
  endfunction

  // Masks come out of reset with every channel bit set.
  function automatic logic [7:0] mask_all(input int nch);
    return 8'((1 << nch) - 1);
  endfunction

  // Wide enough for NCH full-scale 8-bit channels summed without overflow.
  function automatic int out_w(input int nch);
    return 8 + $clog2(nch);
  endfunction

  function automatic logic [7:0] dac_lut(input logic [3:0] lvl);
    logic [7:0] v;
    case (lvl)
      4'h0: v = 8'h00;
      4'h1: v = 8'h01;
      4'h2: v = 8'h02;
      4'h3: v = 8'h03;
      4'h4: v = 8'h05;
      4'h5: v = 8'h07;
      4'h6: v = 8'h0B;
      4'h7: v = 8'h0F;
      4'h8: v = 8'h16;
      4'h9: v = 8'h1F;
      4'hA: v = 8'h2D;
      4'hB: v = 8'h3F;
      4'hC: v = 8'h5A;
      4'hD: v = 8'h7F;
      4'hE: v = 8'hB4;
      default: v = 8'hFF;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/psg_tone_ch.sv
// psg_tone_ch: one square-tone channel (period counter + tone flip-flop).
// Ports:
//   clk, reset  system clock, synchronous active-high reset
//   tick        audio-rate clock enable
//   period      12-bit tone period (0 behaves as 1)
//   tone        square-wave output bit
module psg_tone_ch
  import psg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [11:0] period,
  output logic        tone
);

  logic [11:0] cnt;
  logic [11:0] per_eff;
  logic        wrap;

  // Compare against the live period so a period change lands at the next
  // compare without restarting the count.
  always_comb begin
    per_eff = (period == 12'd0) ? 12'd1 : period;
    wrap    = (cnt >= per_eff - 12'd1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (tick) begin
      if (wrap) begin
        cnt  <= '0;
        tone <= ~tone;
      end else begin
        cnt <= cnt + 12'd1;
      end
    end
  end

endmodule

// File: rtl/psg_multi.sv
// psg_multi: NCH-channel programmable sound generator with shared noise LFSR
// and a 16-shape envelope generator, all on the system clock with an internal
// audio-tick prescaler.
// Ports:
//   clk, reset     system clock, synchronous active-high reset
//   adr            0 = register select, 1 = register data
//   din            write data
//   wr             write strobe, acts on its rising edge
//   dout           combinational readback of the selected register
//   out            registered mono mix (log-DAC weighted sum)
//   out_l, out_r   registered panned mixes (only with PSG_STEREO_EN)
// Build option: define PSG_STEREO_EN to add the pan-left / pan-right mask
// registers and the stereo outputs.
module psg_multi
  import psg_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int PRESC = 16,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   adr,
  input  logic [7:0]             din,
  input  logic                   wr,
  output logic [7:0]             dout,
  output logic [out_w(NCH)-1:0]  out
`ifdef PSG_STEREO_EN
  ,
  output logic [out_w(NCH)-1:0]  out_l,
  output logic [out_w(NCH)-1:0]  out_r
`endif
);

  localparam int OW = out_w(NCH);
  localparam int PW = $clog2(PRESC);

  // Register file
  logic [AW-1:0]          sel;
  logic                   wr_q;
  logic [NCH-1:0][7:0]    tp_lo;
  logic [NCH-1:0][3:0]    tp_hi;
  logic [NCH-1:0][4:0]    amp;
  logic [4:0]             np;
  logic [NCH-1:0]         tdis;
  logic [NCH-1:0]         ndis;
  logic [15:0]            eper;
  logic [3:0]             shape;
`ifdef PSG_STEREO_EN
  logic [NCH-1:0]         pan_l;
  logic [NCH-1:0]         pan_r;
`endif

  logic wr_edge;
  logic shape_wr;

  assign wr_edge  = wr & ~wr_q;
  assign shape_wr = wr_edge & adr & (int'(sel) == reg_shape(NCH));

  // wr_q keeps tracking wr during reset so a strobe held across reset
  // release is not mistaken for a new edge.
  always_ff @(posedge clk) begin
    wr_q <= wr;
    if (reset) begin
      sel   <= '0;
      tp_lo <= '0;
      tp_hi <= '0;
      amp   <= '0;
      np    <= '0;
      tdis  <= NCH'(mask_all(NCH));
      ndis  <= NCH'(mask_all(NCH));
      eper  <= '0;
      shape <= '0;
`ifdef PSG_STEREO_EN
      pan_l <= NCH'(mask_all(NCH));
      pan_r <= NCH'(mask_all(NCH));
`endif
    end else if (wr_edge) begin
      if (!adr) begin
        sel <= din[AW-1:0];
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (int'(sel) == reg_tone_lo(c))  tp_lo[c] <= din;
          if (int'(sel) == reg_tone_hi(c))  tp_hi[c] <= din[3:0];
          if (int'(sel) == reg_amp(NCH, c)) amp[c]   <= din[4:0];
        end
        if (int'(sel) == reg_noise(NCH))  np          <= din[4:0];
        if (int'(sel) == reg_tdis(NCH))   tdis        <= din[NCH-1:0];
        if (int'(sel) == reg_ndis(NCH))   ndis        <= din[NCH-1:0];
        if (int'(sel) == reg_env_lo(NCH)) eper[7:0]   <= din;
        if (int'(sel) == reg_env_hi(NCH)) eper[15:8]  <= din;
        if (int'(sel) == reg_shape(NCH))  shape       <= din[3:0];
`ifdef PSG_STEREO_EN
        if (int'(sel) == reg_pan_l(NCH))  pan_l       <= din[NCH-1:0];
        if (int'(sel) == reg_pan_r(NCH))  pan_r       <= din[NCH-1:0];
`endif
      end
    end
  end

  // Readback; anything not matched (including numbers >= NREG) reads 0.
  always_comb begin
    dout = 8'h00;
    for (int c = 0; c < NCH; c++) begin
      if (int'(sel) == reg_tone_lo(c))  dout = tp_lo[c];
      if (int'(sel) == reg_tone_hi(c))  dout = {4'h0, tp_hi[c]};
      if (int'(sel) == reg_amp(NCH, c)) dout = {3'b000, amp[c]};
    end
    if (int'(sel) == reg_noise(NCH))  dout = {3'b000, np};
    if (int'(sel) == reg_tdis(NCH))   dout = 8'(tdis);
    if (int'(sel) == reg_ndis(NCH))   dout = 8'(ndis);
    if (int'(sel) == reg_env_lo(NCH)) dout = eper[7:0];
    if (int'(sel) == reg_env_hi(NCH)) dout = eper[15:8];
    if (int'(sel) == reg_shape(NCH))  dout = {4'h0, shape};
`ifdef PSG_STEREO_EN
    if (int'(sel) == reg_pan_l(NCH))  dout = 8'(pan_l);
    if (int'(sel) == reg_pan_r(NCH))  dout = 8'(pan_r);
`endif
  end

  // Audio-tick prescaler
  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt == PW'(PRESC - 1));

  always_ff @(posedge clk) begin
    if (reset)     pcnt <= '0;
    else if (tick) pcnt <= '0;
    else           pcnt <= pcnt + PW'(1);
  end

  // Tone channels
  logic [NCH-1:0] tone;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    psg_tone_ch u_ch (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .period ({tp_hi[c], tp_lo[c]}),
      .tone   (tone[c])
    );
  end

  // Noise generator
  logic [4:0]  ncnt;
  logic [4:0]  n_eff;
  logic [16:0] lfsr;
  logic        noise;

  assign n_eff = (np == 5'd0) ? 5'd1 : np;
  assign noise = lfsr[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      ncnt <= '0;
      lfsr <= 17'h00001;
    end else if (tick) begin
      if (ncnt >= n_eff - 5'd1) begin
        ncnt <= '0;
        lfsr <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        ncnt <= ncnt + 5'd1;
      end
    end
  end

  // Envelope generator: ep[3:0] is the position inside a 16-step ramp,
  // ep[4] marks the second (and later) ramp. Held shapes park ep at 16.
  logic [15:0] ecnt;
  logic [15:0] e_eff;
  logic [4:0]  ep;
  logic        e_frozen;
  logic        env_up;
  logic [3:0]  env;

  assign e_eff    = (eper == 16'd0) ? 16'd1 : eper;
  assign e_frozen = ep[4] & (~shape[SH_CONT] | shape[SH_HOLD]);

  always_ff @(posedge clk) begin
    if (reset || shape_wr) begin
      ecnt <= '0;
      ep   <= '0;
    end else if (tick) begin
      if (ecnt >= e_eff - 16'd1) begin
        ecnt <= '0;
        if (!e_frozen) ep <= ep + 5'd1;
      end else begin
        ecnt <= ecnt + 16'd1;
      end
    end
  end

  always_comb begin
    env_up = shape[SH_ATT] ^ (ep[4] & shape[SH_ALT]);
    env    = env_up ? ep[3:0] : ~ep[3:0];
    if (ep[4]) begin
      if (!shape[SH_CONT])     env = 4'h0;
      else if (shape[SH_HOLD]) env = (shape[SH_ATT] ^ shape[SH_ALT]) ? 4'hF : 4'h0;
    end
  end

  // Mixer / DAC (p0: combinational sum of current levels)
  logic [NCH-1:0][3:0] lvl;
  logic [OW-1:0]       sum_p0;
`ifdef PSG_STEREO_EN
  logic [OW-1:0]       suml_p0;
  logic [OW-1:0]       sumr_p0;
`endif

  always_comb begin
    lvl = '0;
    for (int c = 0; c < NCH; c++) begin
      if ((tone[c] | tdis[c]) & (noise | ndis[c]))
        lvl[c] = amp[c][4] ? env : amp[c][3:0];
    end
  end

  always_comb begin
    sum_p0 = '0;
`ifdef PSG_STEREO_EN
    suml_p0 = '0;
    sumr_p0 = '0;
`endif
    for (int c = 0; c < NCH; c++) begin
      sum_p0 = sum_p0 + OW'(dac_lut(lvl[c]));
`ifdef PSG_STEREO_EN
      if (pan_l[c]) suml_p0 = suml_p0 + OW'(dac_lut(lvl[c]));
      if (pan_r[c]) sumr_p0 = sumr_p0 + OW'(dac_lut(lvl[c]));
`endif
    end
  end

  // p0 -> output register
  always_ff @(posedge clk) begin
    if (reset) begin
      out   <= '0;
`ifdef PSG_STEREO_EN
      out_l <= '0;
      out_r <= '0;
`endif
    end else begin
      out   <= sum_p0;
`ifdef PSG_STEREO_EN
      out_l <= suml_p0;
      out_r <= sumr_p0;
`endif
    end
  end

endmodule
